// File: rtl/dp_trace_buffer.sv
// Circular retire-trace capture unit: arm, trigger on PC match or force, record POST_TRIG more samples, then stream oldest-first.
// Optional macro DP_TRACE_TIMESTAMP_EN adds a 32-bit cycle stamp per record and the rd_ts port.
module dp_trace_buffer #(
   parameter int XLEN      = 32,
   parameter int DEPTH     = 16,
   parameter int POST_TRIG = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     smp_valid,
   input  logic [XLEN-1:0]          smp_pc,
   input  logic [XLEN-1:0]          smp_inst,
   input  logic [XLEN-1:0]          smp_wdata,
   input  logic                     smp_we,
   input  logic                     arm,
   input  logic                     abort,
   input  logic                     trig_en,
   input  logic [XLEN-1:0]          trig_pc,
   input  logic                     force_trig,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [XLEN-1:0]          rd_pc,
   output logic [XLEN-1:0]          rd_inst,
   output logic [XLEN-1:0]          rd_wdata,
   output logic                     rd_we,
   output logic                     rd_last,
`ifdef DP_TRACE_TIMESTAMP_EN
   output logic [31:0]              rd_ts,
`endif
   output logic [1:0]               state,
   output logic [$clog2(DEPTH):0]   fill,
   output logic                     done
);

   localparam int AW = $clog2(DEPTH);
`ifdef DP_TRACE_TIMESTAMP_EN
   localparam int RW = 3*XLEN + 1 + 32;
`else
   localparam int RW = 3*XLEN + 1;
`endif
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("dp_trace_buffer: DEPTH must be a power of two >= 4");
   end
   if (POST_TRIG < 0 || POST_TRIG > DEPTH - 1) begin : g_bad_post
      $error("dp_trace_buffer: POST_TRIG must be in 0..DEPTH-1");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_POST  = 2'd2,
      S_DUMP  = 2'd3
   } state_t;

   state_t         st_q, st_d;
   logic [AW-1:0]  wptr_q, wptr_d;
   logic [AW:0]    fill_q, fill_d;
   logic [AW-1:0]  post_q, post_d;
   logic           pend_q, pend_d;
   logic [AW-1:0]  fidx_q, fidx_d;
   logic [AW:0]    frem_q, frem_d;
   logic [AW:0]    orem_q, orem_d;
   logic           done_d;
   logic           wr_en;
   logic           trig_hit;
   logic           fetch;
   logic           accept;
   logic [RW-1:0]  wr_word;
   logic [RW-1:0]  rd_word;
   logic [RW-1:0]  mem [DEPTH];

`ifdef DP_TRACE_TIMESTAMP_EN
   logic [31:0]    ts_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ts_q <= '0;
      else      ts_q <= ts_q + 32'd1;
   end

   assign wr_word = {ts_q, smp_we, smp_wdata, smp_inst, smp_pc};
`else
   assign wr_word = {smp_we, smp_wdata, smp_inst, smp_pc};
`endif

   // A force_trig seen without a sample is remembered in pend_q until the next valid sample.
   always_comb begin
      st_d     = st_q;
      wptr_d   = wptr_q;
      fill_d   = fill_q;
      post_d   = post_q;
      pend_d   = pend_q;
      fidx_d   = fidx_q;
      frem_d   = frem_q;
      orem_d   = orem_q;
      done_d   = 1'b0;
      wr_en    = 1'b0;
      trig_hit = smp_valid && ((trig_en && smp_pc == trig_pc) || force_trig || pend_q);
      accept   = rd_valid && rd_ready;
      fetch    = (st_q == S_DUMP) && (frem_q != '0) && (!rd_valid || rd_ready);
      case (st_q)
         S_IDLE: begin
            if (arm) begin
               st_d   = S_ARMED;
               wptr_d = '0;
               fill_d = '0;
               pend_d = 1'b0;
            end
         end
         S_ARMED: begin
            wr_en = smp_valid;
            if (force_trig && !smp_valid) pend_d = 1'b1;
            if (trig_hit) begin
               pend_d = 1'b0;
               if (POST_TRIG == 0) begin
                  st_d = S_DUMP;
               end else begin
                  st_d   = S_POST;
                  post_d = AW'(POST_TRIG);
               end
            end
         end
         S_POST: begin
            if (smp_valid) begin
               wr_en  = 1'b1;
               post_d = post_q - AW'(1);
               if (post_q == AW'(1)) st_d = S_DUMP;
            end
         end
         default: begin
            if (fetch) begin
               fidx_d = fidx_q + AW'(1);
               frem_d = frem_q - (AW+1)'(1);
            end
            if (accept) begin
               orem_d = orem_q - (AW+1)'(1);
               if (orem_q == (AW+1)'(1)) begin
                  done_d = 1'b1;
                  st_d   = S_IDLE;
               end
            end
         end
      endcase
      if (wr_en) begin
         wptr_d = wptr_q + AW'(1);
         if (fill_q != FULL) fill_d = fill_q + (AW+1)'(1);
      end
      // Readout window is fixed from the pointer/fill produced by the final write.
      if (st_q != S_DUMP && st_d == S_DUMP) begin
         fidx_d = wptr_d - fill_d[AW-1:0];
         frem_d = fill_d;
         orem_d = fill_d;
      end
      if (abort) begin
         st_d   = S_IDLE;
         done_d = 1'b0;
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q   <= S_IDLE;
         wptr_q <= '0;
         fill_q <= '0;
         post_q <= '0;
         pend_q <= 1'b0;
         fidx_q <= '0;
         frem_q <= '0;
         orem_q <= '0;
         done   <= 1'b0;
      end else begin
         st_q   <= st_d;
         wptr_q <= wptr_d;
         fill_q <= fill_d;
         post_q <= post_d;
         pend_q <= pend_d;
         fidx_q <= fidx_d;
         frem_q <= frem_d;
         orem_q <= orem_d;
         done   <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr_q] <= wr_word;
   end

   assign rd_word = mem[fidx_q];

   // Output register doubles as the synchronous RAM read stage; it refills whenever it is empty or being drained.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_valid <= 1'b0;
         rd_pc    <= '0;
         rd_inst  <= '0;
         rd_wdata <= '0;
         rd_we    <= 1'b0;
`ifdef DP_TRACE_TIMESTAMP_EN
         rd_ts    <= '0;
`endif
      end else if (abort) begin
         rd_valid <= 1'b0;
      end else if (fetch) begin
         rd_valid <= 1'b1;
         {rd_we, rd_wdata, rd_inst, rd_pc} <= rd_word[3*XLEN:0];
`ifdef DP_TRACE_TIMESTAMP_EN
         rd_ts    <= rd_word[RW-1 -: 32];
`endif
      end else if (accept) begin
         rd_valid <= 1'b0;
      end
   end

   assign rd_last = rd_valid && (orem_q == (AW+1)'(1));
   assign state   = st_q;
   assign fill    = fill_q;

endmodule
